// File: rtl/data_mem_dump_master_if.sv
// Memory read port and byte stream bundle used by data_mem_dump_master.
// The master modport is the dump engine; the slave side is the memory plus the UART feed.
interface data_mem_dump_master_if #(
  parameter int unsigned RAM_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_rd;
  logic                  o_mem_wr;
  logic [RAM_WIDTH-1:0]  i_mem_data;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;

  modport master (
    output o_mem_addr, o_mem_rd, o_mem_wr, o_tx_data, o_tx_valid,
    input  i_mem_data, i_tx_ready
  );

  modport slave (
    input  o_mem_addr, o_mem_rd, o_mem_wr, o_tx_data, o_tx_valid,
    output i_mem_data, i_tx_ready
  );
endinterface

// File: rtl/data_mem_dump_master.sv
// Sweeps data memory words 0..last after a CPU halt and streams each word MSB byte first.
// Optional DUMP_CHECKSUM_EN appends an 8-bit running sum byte after the last data byte.
module data_mem_dump_master #(
  parameter int unsigned RAM_WIDTH  = 16,
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_last_addr,
  data_mem_dump_master_if.master bus,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned BYTES = RAM_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  if ((RAM_WIDTH % 8) != 0 || ADDR_WIDTH != $clog2(RAM_DEPTH)) begin : g_bad_cfg
    $error("data_mem_dump_master: inconsistent RAM_WIDTH/RAM_DEPTH/ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_SEND,
`ifdef DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_FIN
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [RAM_WIDTH-1:0]  word_q;
  logic [IDX_W-1:0]      idx_q;
  logic [7:0]            tx_data_q;
  logic                  tx_valid_q;
  logic                  rd_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]            sum_q;
`endif

  logic [IDX_W-1:0]      idx_dec;
  logic [7:0]            next_byte;

  // Next lower byte of the captured word, used when the current byte is accepted.
  assign idx_dec   = idx_q - IDX_W'(1);
  assign next_byte = word_q[{idx_dec, 3'b000} +: 8];

  assign bus.o_mem_addr = addr_q;
  assign bus.o_mem_rd   = rd_q;
  assign bus.o_mem_wr   = 1'b0;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_valid = tx_valid_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            last_q  <= i_last_addr;
            addr_q  <= '0;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_REQ;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
        // Memory samples the address on the falling edge inside this cycle.
        S_REQ: begin
          rd_q    <= 1'b0;
          state_q <= S_CAP;
        end
        S_CAP: begin
          word_q     <= bus.i_mem_data;
          idx_q      <= IDX_W'(BYTES - 1);
          tx_data_q  <= bus.i_mem_data[RAM_WIDTH-1 -: 8];
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (bus.i_tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
            sum_q <= sum_q + tx_data_q;
`endif
            if (idx_q != '0) begin
              idx_q     <= idx_dec;
              tx_data_q <= next_byte;
            end else if (addr_q == last_q) begin
`ifdef DUMP_CHECKSUM_EN
              tx_data_q <= sum_q + tx_data_q;
              state_q   <= S_CSUM;
`else
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_FIN;
`endif
            end else begin
              // Termination is by compare, so addr never wraps past the last word.
              tx_valid_q <= 1'b0;
              addr_q     <= addr_q + ADDR_WIDTH'(1);
              rd_q       <= 1'b1;
              state_q    <= S_REQ;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (bus.i_tx_ready) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_FIN;
          end
        end
`endif
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_dump_master.sv
// Self-checking bench for data_mem_dump_master: table of dump scenarios checked against a
// word-list reference model, plus hand-written reset-abort sequence.
module tb_data_mem_dump_master;

  localparam int unsigned RW    = 16;
  localparam int unsigned RD    = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned BYTES = RW / 8;
`ifdef DUMP_CHECKSUM_EN
  localparam int unsigned CS = 1;
`else
  localparam int unsigned CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          busy;
  logic          done;

  data_mem_dump_master_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

  data_mem_dump_master #(.RAM_WIDTH(RW), .RAM_DEPTH(RD), .ADDR_WIDTH(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_start    (start),
    .i_last_addr(last_addr),
    .bus        (bus),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] mem [RD];

  // Memory captures on the falling edge while enabled (rd xor wr).
  always @(negedge clk) begin
    if (bus.o_mem_rd ^ bus.o_mem_wr) bus.i_mem_data <= mem[bus.o_mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int ready_pct = 100;

  initial begin
    bus.i_tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_tx_ready = ($urandom_range(99) < ready_pct);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Protocol monitor sampled on the falling edge.
  bit          mon_en = 1'b0;
  logic [7:0]  got_q[$];
  int          rd_addr_q[$];
  int          done_cnt;
  bit          prev_rd, prev_stall;
  logic [7:0]  prev_data;

  always @(negedge clk) begin
    if (mon_en) begin
      check("mem_wr_low", 64'(bus.o_mem_wr), 64'd0);
      if (prev_stall) begin
        check("hold_valid", 64'(bus.o_tx_valid), 64'd1);
        check("hold_data", 64'(bus.o_tx_data), 64'(prev_data));
      end
      if (bus.o_mem_rd) begin
        rd_addr_q.push_back(int'(bus.o_mem_addr));
        check("rd_one_cycle", 64'(prev_rd), 64'd0);
      end
      if (bus.o_tx_valid && bus.i_tx_ready) got_q.push_back(bus.o_tx_data);
      if (done) done_cnt++;
      prev_rd    = bus.o_mem_rd;
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
      prev_data  = bus.o_tx_data;
    end
  end

  typedef struct {
    int          mode;      // 0: 1234/ABCD/0F0F, 1: mem[0]=BEEF, 2: mem[k]=k, 3: random
    int          last;
    int          pct;       // 0 means stall first, then release
    int          nbytes;
    bit          has_const;
    logic [15:0] w_first;
    logic [15:0] w_last;
    bit          perturb;
    bit          fin_start;
  } vec_t;

  vec_t tbl [7];

  task automatic fill_mem(input int mode);
    for (int k = 0; k < int'(RD); k++) begin
      mem[k] = 16'($urandom);
      case (mode)
        0: if (k == 0) mem[k] = 16'h1234; else if (k == 1) mem[k] = 16'hABCD;
           else if (k == 2) mem[k] = 16'h0F0F;
        1: if (k == 0) mem[k] = 16'hBEEF;
        2: mem[k] = 16'(k);
        default: ;
      endcase
    end
  endtask

  // Reference: every word in address order, most significant byte first, optional sum byte.
  task automatic build_exp(input int last, output logic [7:0] exp_q[$]);
    logic [7:0]  sum;
    logic [RW-1:0] w;
    exp_q.delete();
    sum = 8'd0;
    for (int a = 0; a <= last; a++) begin
      w = mem[a];
      for (int b = int'(BYTES) - 1; b >= 0; b--) begin
        exp_q.push_back(w[8*b +: 8]);
        sum = sum + w[8*b +: 8];
      end
    end
    if (CS != 0) exp_q.push_back(sum);
  endtask

  task automatic mon_clear();
    got_q.delete();
    rd_addr_q.delete();
    done_cnt   = 0;
    prev_rd    = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
  endtask

  task automatic pulse_start(input int last);
    @(posedge clk);
    #2;
    last_addr = AW'(last);
    start     = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic run_dump(input vec_t v);
    logic [7:0] exp_q[$];
    int cyc, bad, limit, n;
    fill_mem(v.mode);
    build_exp(v.last, exp_q);
    mon_clear();
    ready_pct = (v.pct == 0) ? 0 : v.pct;
    mon_en = 1'b1;
    pulse_start(v.last);
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'd1);
    if (v.perturb) begin
      repeat (4) @(negedge clk);
      start     = 1'b1;
      last_addr = AW'(7);
      @(negedge clk);
      start = 1'b0;
    end
    if (v.pct == 0) begin
      repeat (40) @(negedge clk);
      check("stall_rd_count", 64'(rd_addr_q.size()), 64'd1);
      check("stall_no_bytes", 64'(got_q.size()), 64'd0);
      check("stall_valid", 64'(bus.o_tx_valid), 64'd1);
      ready_pct = 100;
    end
    limit = (v.last + 1) * 40 + 200;
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("busy_in_fin", 64'(busy), 64'd1);
    if (v.fin_start) begin
      start     = 1'b1;
      last_addr = AW'(v.last);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_clear", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check("idle_after_fin", 64'({busy, bus.o_tx_valid, bus.o_mem_rd}), 64'd0);
    mon_en = 1'b0;

    check("byte_count", 64'(got_q.size()), 64'(exp_q.size()));
    check("byte_count_const", 64'(got_q.size()), 64'(v.nbytes + int'(CS)));
    bad = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) bad++;
    check("byte_stream_mismatches", 64'(bad), 64'd0);
    check("rd_pulses", 64'(rd_addr_q.size()), 64'(v.last + 1));
    bad = 0;
    foreach (rd_addr_q[i]) if (rd_addr_q[i] != i) bad++;
    check("rd_addr_order", 64'(bad), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    if (v.has_const && got_q.size() >= 2 + int'(CS)) begin
      n = got_q.size() - int'(CS);
      check("first_word", 64'({got_q[0], got_q[1]}), 64'(v.w_first));
      check("last_word", 64'({got_q[n-2], got_q[n-1]}), 64'(v.w_last));
    end
  endtask

  initial begin
    vec_t rv;
    int cyc;
    tbl[0] = '{0, 2,    100, 6,    1'b1, 16'h1234, 16'h0F0F, 1'b0, 1'b0};
    tbl[1] = '{1, 0,    100, 2,    1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
    tbl[2] = '{0, 2,    30,  6,    1'b1, 16'h1234, 16'h0F0F, 1'b0, 1'b0};
    tbl[3] = '{2, 1023, 100, 2048, 1'b1, 16'h0000, 16'h03FF, 1'b0, 1'b0};
    tbl[4] = '{0, 2,    100, 6,    1'b1, 16'h1234, 16'h0F0F, 1'b1, 1'b0};
    tbl[5] = '{3, 9,    40,  20,   1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[6] = '{2, 3,    0,   8,    1'b1, 16'h0000, 16'h0003, 1'b0, 1'b0};

    #12;
    check("reset_outputs", 64'({bus.o_mem_addr, bus.o_mem_rd, bus.o_mem_wr, bus.o_tx_data,
                                bus.o_tx_valid, busy, done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) run_dump(tbl[t]);

    // Reset abort while the second byte of word 5 is on the stream.
    fill_mem(2);
    mon_clear();
    ready_pct = 100;
    mon_en = 1'b1;
    pulse_start(9);
    cyc = 0;
    while (got_q.size() < 12 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    mon_en = 1'b0;
    check("abort_point_bytes", 64'(got_q.size()), 64'd12);
    check("abort_point_data", 64'(bus.o_tx_data), 64'h05);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({bus.o_mem_addr, bus.o_mem_rd, bus.o_mem_wr, bus.o_tx_data,
                                      bus.o_tx_valid, busy, done}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 64'({busy, done, bus.o_tx_valid, bus.o_mem_rd}), 64'd0);
    rv = '{2, 1, 100, 4, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0};
    run_dump(rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
